// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared types and helpers for the lane-merging register file.
//   wb_mode_t  : write-back merge mode carried on wr_mode
//   BYTE_W / HALF_W / LANES_32 : lane geometry constants
//   is_legal() : whether a (mode, offset) pair may commit
package regfile_pkg;

    typedef enum logic [2:0] {
        WB_WORD = 3'd0,
        WB_LB   = 3'd1,
        WB_LBU  = 3'd2,
        WB_LH   = 3'd3,
        WB_LHU  = 3'd4,
        WB_LWL  = 3'd5,
        WB_LWR  = 3'd6
    } wb_mode_t;

    localparam int BYTE_W   = 8;
    localparam int HALF_W   = 16;
    localparam int LANES_32 = 4;

    // Halfword loads from an odd byte address are dropped; everything else commits.
    function automatic logic is_legal(input wb_mode_t mode, input logic [1:0] off);
        return !(((mode == WB_LH) || (mode == WB_LHU)) && off[0]);
    endfunction

endpackage

// File: rtl/regfile_if.sv
// regfile_if -- bundle of the register file's read, write-back and scoreboard signals.
//   master : core side (drives selectors, write-back and pend_set; sees data/busy/status)
//   slave  : register file side
// Handshake: there is no backpressure. wr_en and pend_set are single-cycle strobes
// sampled at posedge clk; rd_data/rd_busy are combinational responses to rd_addr
// in the same cycle; misalign is a registered one-cycle pulse.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_RD   = 2
);
    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD*DATA_W-1:0] rd_data;
    logic [N_RD-1:0]        rd_busy;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    wb_mode_t               wr_mode;
    logic [1:0]             wr_off;
    logic                   pend_set;
    logic [ADDR_W-1:0]      pend_addr;
    logic                   misalign;
    logic [DATA_W-1:0]      regv0;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_mode, wr_off, pend_set, pend_addr,
        input  rd_data, rd_busy, misalign, regv0
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_mode, wr_off, pend_set, pend_addr,
        output rd_data, rd_busy, misalign, regv0
    );
endinterface

// File: rtl/regfile_lane_merge.sv
// regfile_lane_merge -- combinational write-back lane merge.
//   old_val : current register contents
//   wr_data : aligned memory word (or full result for WORD)
//   mode    : wb_mode_t merge mode
//   off     : effective-address byte offset
//   new_val : merged register value
//   legal   : merge may commit (false for odd-offset halfword loads)
module regfile_lane_merge
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] old_val,
    input  logic [DATA_W-1:0] wr_data,
    input  wb_mode_t          mode,
    input  logic [1:0]        off,
    output logic [DATA_W-1:0] new_val,
    output logic              legal
);
    localparam int LANES = DATA_W / BYTE_W;

    logic [BYTE_W-1:0] sel_byte;
    logic [HALF_W-1:0] sel_half;
    int                n;

    always_comb begin
        n        = int'(off);
        sel_byte = wr_data[BYTE_W*n +: BYTE_W];
        sel_half = wr_data[HALF_W*int'(off[1]) +: HALF_W];
        legal    = is_legal(mode, off);
        new_val  = old_val;
        case (mode)
            WB_WORD: new_val = wr_data;
            WB_LB:   new_val = {{(DATA_W-BYTE_W){sel_byte[BYTE_W-1]}}, sel_byte};
            WB_LBU:  new_val = {{(DATA_W-BYTE_W){1'b0}}, sel_byte};
            WB_LH:   new_val = {{(DATA_W-HALF_W){sel_half[HALF_W-1]}}, sel_half};
            WB_LHU:  new_val = {{(DATA_W-HALF_W){1'b0}}, sel_half};
            // Unaligned-left: the low n+1 memory bytes fill the top of the register.
            WB_LWL: begin
                for (int i = 0; i < LANES; i++) begin
                    if (i >= LANES - 1 - n)
                        new_val[BYTE_W*i +: BYTE_W] = wr_data[BYTE_W*(i-(LANES-1-n)) +: BYTE_W];
                end
            end
            // Unaligned-right: memory bytes n..top fill the bottom of the register.
            WB_LWR: begin
                for (int i = 0; i < LANES; i++) begin
                    if (i <= LANES - 1 - n)
                        new_val[BYTE_W*i +: BYTE_W] = wr_data[BYTE_W*(i+n) +: BYTE_W];
                end
            end
            default: new_val = wr_data;
        endcase
    end
endmodule

// File: rtl/regfile_lanes.sv
// regfile_lanes -- MIPS register file: N_RD combinational read ports, one lane-merging
// write-back port, per-register pending-load scoreboard.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : regfile_if.slave (read selectors/data/busy, write-back, pend_set,
//                misalign pulse, regv0 debug view of register REG_DBG)
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle legal write to any
// read port selecting the destination (data and busy). Without it reads see storage only.
module regfile_lanes
    import regfile_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int N_RD    = 2,
    parameter int REG_DBG = 2
) (
    input logic      clk,
    input logic      reset,
    regfile_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic              misalign_q;
    logic [DATA_W-1:0] merged;
    logic              legal;
    logic              commit;

    regfile_lane_merge #(.DATA_W(DATA_W)) u_merge (
        .old_val (regs[bus.wr_addr]),
        .wr_data (bus.wr_data),
        .mode    (bus.wr_mode),
        .off     (bus.wr_off),
        .new_val (merged),
        .legal   (legal)
    );

    // r0 is never written, so it stays zero and its busy bit is never cleared by a write.
    assign commit = bus.wr_en && legal && (bus.wr_addr != '0);

    // A newer load to the same register must remain outstanding, so set is applied last.
    always_comb begin
        busy_next = busy;
        if (commit)
            busy_next[bus.wr_addr] = 1'b0;
        if (bus.pend_set && (bus.pend_addr != '0))
            busy_next[bus.pend_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy       <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (commit)
                regs[bus.wr_addr] <= merged;
            busy       <= busy_next;
            misalign_q <= bus.wr_en && !legal;
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] sel;
        assign sel = bus.rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        logic hit;
        assign hit = commit && (bus.wr_addr == sel);
        assign bus.rd_data[k*DATA_W +: DATA_W] = hit ? merged : regs[sel];
        assign bus.rd_busy[k]                  = busy[sel] && !hit;
`else
        assign bus.rd_data[k*DATA_W +: DATA_W] = regs[sel];
        assign bus.rd_busy[k]                  = busy[sel];
`endif
    end

    assign bus.misalign = misalign_q;
    assign bus.regv0    = regs[REG_DBG];
endmodule

// File: tb/tb_regfile_lanes.sv
module tb_regfile_lanes;
  import regfile_pkg::*;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int N_RD    = 2;
  localparam int REG_DBG = 2;
  // expected entry: {kind[2:0], port[1:0], value[31:0]}
  localparam int EW = 37;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD)) bus ();

  regfile_lanes #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .REG_DBG(REG_DBG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  logic        m_mis;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Memory-style merge: sign/zero extension and shifted masks on whole words.
  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] d,
                                              input int mode, input int off, output logic ok);
    logic [31:0] b, h;
    int sh;
    ok = 1'b1;
    b  = (d >> (8 * off)) & 32'hFF;
    h  = (d >> (16 * (off / 2))) & 32'hFFFF;
    case (mode)
      1: return {{24{b[7]}}, b[7:0]};
      2: return b;
      3, 4: begin
        ok = (off % 2) == 0;
        return (mode == 3) ? {{16{h[15]}}, h[15:0]} : h;
      end
      5: begin
        sh = 8 * (3 - off);
        return (d << sh) | (old & ((32'h1 << sh) - 32'h1));
      end
      6: begin
        sh = 8 * off;
        return (d >> sh) | (old & ~(32'hFFFF_FFFF >> sh));
      end
      default: return d;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
    m_mis = 1'b0;
  endfunction

  function automatic void push_exp(input int kind, input int port, input logic [31:0] v);
    exp_q.push_back({3'(kind), 2'(port), v});
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle, queues every expected output for that cycle, then advances
  // the model at the clock edge. cexp_* adds a literal expectation on read port 0.
  logic        cexp_en  = 1'b0;
  logic [31:0] cexp_val = 32'h0;

  task automatic drive(input logic we, input int waddr, input logic [31:0] wdata,
                       input int mode, input int off, input logic ps, input int paddr,
                       input int ra0, input int ra1);
    logic [31:0] nv;
    logic ok, hit, commit;
    int ra [2];
    ra[0] = ra0;
    ra[1] = ra1;
    bus.wr_en     = we;
    bus.wr_addr   = 5'(waddr);
    bus.wr_data   = wdata;
    bus.wr_mode   = wb_mode_t'(3'(mode));
    bus.wr_off    = 2'(off);
    bus.pend_set  = ps;
    bus.pend_addr = 5'(paddr);
    bus.rd_addr   = {5'(ra1), 5'(ra0)};
    nv     = model_merge(m_regs[waddr], wdata, mode, off, ok);
    commit = we && ok && (waddr != 0);
    for (int k = 0; k < 2; k++) begin
      hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
      hit = commit && (waddr == ra[k]);
`endif
      push_exp(0, k, hit ? nv : m_regs[ra[k]]);
      push_exp(1, k, {31'b0, m_busy[ra[k]] && !hit});
    end
    push_exp(2, 0, {31'b0, m_mis});
    push_exp(3, 0, m_regs[REG_DBG]);
    if (cexp_en) push_exp(0, 0, cexp_val);
    cexp_en = 1'b0;
    @(posedge clk);
    if (commit) begin
      m_regs[waddr] = nv;
      m_busy[waddr] = 1'b0;
    end
    if (ps && paddr != 0) m_busy[paddr] = 1'b1;
    m_mis = we && !ok;
    #1;
  endtask

  task automatic idle_read(input int ra0, input int ra1);
    drive(1'b0, 0, 32'h0, 0, 0, 1'b0, 0, ra0, ra1);
  endtask

  task automatic read_expect(input int ra, input logic [31:0] v);
    cexp_en  = 1'b1;
    cexp_val = v;
    idle_read(ra, ra);
  endtask

  task automatic word(input int addr, input logic [31:0] v);
    drive(1'b1, addr, v, 0, 0, 1'b0, 0, addr, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      logic [31:0]   act;
      int kind, port;
      string nm;
      e    = exp_q.pop_front();
      kind = int'(e[36:34]);
      port = int'(e[33:32]);
      case (kind)
        0: begin act = bus.rd_data[port*32 +: 32];   nm = "rd_data";  end
        1: begin act = {31'b0, bus.rd_busy[port]};   nm = "rd_busy";  end
        2: begin act = {31'b0, bus.misalign};        nm = "misalign"; end
        default: begin act = bus.regv0;              nm = "regv0";    end
      endcase
      n_checks++;
      if (act === e[31:0]) n_pass++;
      else $display("FAIL %s port%0d t=%0t: got %h, expected %h", nm, port, $time, act, e[31:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    bus.rd_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.wr_mode = WB_WORD; bus.wr_off = '0; bus.pend_set = 1'b0; bus.pend_addr = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    // reset dominates a concurrent write and pend_set to r5
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'h1234_5678;
    bus.pend_set = 1'b1; bus.pend_addr = 5'd5;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    read_expect(5, 32'h0);

    // WORD write to $v0, same-cycle read then next-cycle read
    drive(1'b1, 2, 32'hDEAD_BEEF, 0, 0, 1'b0, 0, 2, 2);
    read_expect(2, 32'hDEAD_BEEF);

    // partial-load merges with wr_data = 0x8899AABB
    drive(1'b1, 3, 32'h8899_AABB, 1, 1, 1'b0, 0, 3, 0);
    read_expect(3, 32'hFFFF_FFAA);
    drive(1'b1, 3, 32'h8899_AABB, 2, 3, 1'b0, 0, 3, 0);
    read_expect(3, 32'h0000_0088);
    drive(1'b1, 3, 32'h8899_AABB, 3, 2, 1'b0, 0, 3, 0);
    read_expect(3, 32'hFFFF_8899);
    word(4, 32'h1122_3344);
    drive(1'b1, 4, 32'h8899_AABB, 5, 1, 1'b0, 0, 4, 0);
    read_expect(4, 32'hAABB_3344);
    word(4, 32'h1122_3344);
    drive(1'b1, 4, 32'h8899_AABB, 6, 2, 1'b0, 0, 4, 0);
    read_expect(4, 32'h1122_8899);

    // misaligned LHU: dropped, one-cycle misalign pulse, busy untouched
    word(7, 32'h0000_0055);
    drive(1'b0, 0, 32'h0, 0, 0, 1'b1, 7, 7, 0);
    drive(1'b1, 7, 32'h8899_AABB, 4, 1, 1'b0, 0, 7, 7);
    read_expect(7, 32'h0000_0055);
    idle_read(7, 0);
    word(7, 32'h0000_0055);

    // scoreboard: set, set+write same cycle, later plain write
    drive(1'b0, 0, 32'h0, 0, 0, 1'b1, 9, 9, 9);
    idle_read(9, 9);
    drive(1'b1, 9, 32'hCAFE_0009, 0, 0, 1'b1, 9, 9, 9);
    idle_read(9, 9);
    drive(1'b1, 9, 32'hCAFE_1009, 0, 0, 1'b0, 0, 9, 9);
    idle_read(9, 9);

    // r0: writes discarded, never busy
    drive(1'b1, 0, 32'hFFFF_FFFF, 0, 0, 1'b1, 0, 0, 0);
    read_expect(0, 32'h0);

    // randomized traffic on a small register window to force collisions
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom(),
            $urandom_range(0, 6), $urandom_range(0, 3),
            1'($urandom_range(0, 3) == 0), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7));
    end
    idle_read(2, 3);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
